calc_core: RTL and testbench

CALC_CORE -- requirements
Module: calc_core

---
 rtl/calc_core.sv | 119 +++++++++++
 tb/tb_calc_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/calc_core.sv
// Sequential 32x32 signed shift-add multiplier that streams its result LSB-first.
// Define CALC_CORE_SAT_EN to saturate the 32-bit result instead of wrapping it.
module calc_core #(
  parameter int OUT_BYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic signed [31:0] a0,
  input  logic signed [31:0] a1,
  input  logic               start_calc,
  output logic               core_busy,
  output logic        [31:0] result,
  output logic               result_valid,
  output logic        [7:0]  out_byte,
  output logic               out_strobe
);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, DONE, STREAM} state_t;

  localparam logic [1:0] LAST_BYTE = 2'(OUT_BYTES - 1);

  state_t      state, state_nxt;
  logic        arm;
  logic        sign;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  cnt;
  logic [1:0]  bidx;
  logic [31:0] res_nxt;
  logic        accept;

  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  assign accept = (state == IDLE) && start_calc && arm;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = MUL;
      MUL:     if (cnt == 6'd31) state_nxt = DONE;
      DONE:    state_nxt = STREAM;
      STREAM:  if (bidx == LAST_BYTE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CALC_CORE_SAT_EN
  localparam logic signed [63:0] MAX_POS = 64'sd2147483647;
  localparam logic signed [63:0] MIN_NEG = -64'sd2147483648;
  logic signed [63:0] prod;

  always_comb begin
    prod = sign ? $signed(~acc + 64'd1) : $signed(acc);
    if (prod > MAX_POS)      res_nxt = 32'h7FFF_FFFF;
    else if (prod < MIN_NEG) res_nxt = 32'h8000_0000;
    else                     res_nxt = prod[31:0];
  end
`else
  // Low word of the two's-complement negation only depends on the low word.
  always_comb begin
    res_nxt = sign ? (~acc[31:0] + 32'd1) : acc[31:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      arm          <= 1'b1;
      core_busy    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      out_byte     <= '0;
      out_strobe   <= 1'b0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      cnt          <= '0;
      sign         <= 1'b0;
      bidx         <= '0;
    end else if (ena) begin
      state        <= state_nxt;
      core_busy    <= (state != IDLE) || accept;
      result_valid <= (state == DONE);
      out_strobe   <= (state == STREAM);
      out_byte     <= (state == STREAM) ? result[{bidx, 3'b000} +: 8] : 8'h00;

      if (accept)           arm <= 1'b0;
      else if (!start_calc) arm <= 1'b1;

      case (state)
        LOAD: begin
          mcand  <= {32'h0, mag(a0)};
          mplier <= mag(a1);
          sign   <= a0[31] ^ a1[31];
          acc    <= '0;
          cnt    <= '0;
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
        end
        DONE: begin
          result <= res_nxt;
          bidx   <= '0;
        end
        STREAM:  bidx <= bidx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: stimulus queues expected results/bytes with their
// cycle stamps, a negedge monitor pops and compares whatever the core emits.
module tb_calc_core;

  localparam int OUT_BYTES = 4;
`ifdef CALC_CORE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               ena;
  logic signed [31:0] a0;
  logic signed [31:0] a1;
  logic               start_calc;
  logic               core_busy;
  logic        [31:0] result;
  logic               result_valid;
  logic        [7:0]  out_byte;
  logic               out_strobe;

  calc_core #(.OUT_BYTES(OUT_BYTES)) dut (
    .clk(clk), .rst(rst), .ena(ena), .a0(a0), .a1(a1), .start_calc(start_calc),
    .core_busy(core_busy), .result(result), .result_valid(result_valid),
    .out_byte(out_byte), .out_strobe(out_strobe)
  );

  typedef struct {
    logic [31:0] v;
    int          c;
  } exp_t;

  exp_t rq[$];
  exp_t bq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decoupled from stimulus, compares every emitted result and byte.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_result_valid: got result %h, expected no pulse (cycle %0d)", result, cyc);
      end else begin
        e = rq.pop_front();
        chk("result_value", result, e.v);
        chk("result_cycle", 32'(cyc), 32'(e.c));
      end
    end
    if (out_strobe) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_strobe: got byte %h, expected no strobe (cycle %0d)", out_byte, cyc);
      end else begin
        e = bq.pop_front();
        chk("byte_value", 32'(out_byte), e.v);
        chk("byte_cycle", 32'(cyc), 32'(e.c));
      end
    end else begin
      chk("idle_byte_zero", 32'(out_byte), 32'h0);
    end
  end

  // mode 0: plain, 1: ena stalls in MUL and STREAM, 2: operand/start scrambling while busy
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp,
                       input int hold, input int mode);
    int t0, extra, len;
    logic [31:0] tmp;
    @(negedge clk);
    a0 = x; a1 = y; start_calc = 1'b1;
    t0 = cyc + 1;
    extra = (mode == 1) ? 7 : 0;
    rq.push_back('{exp, t0 + 34 + ((mode == 1) ? 5 : 0)});
    for (int k = 0; k < OUT_BYTES; k++) begin
      tmp = exp >> (8 * k);
      if (mode == 1) begin
        if (k == 0) begin
          bq.push_back('{{24'h0, tmp[7:0]}, t0 + 40});
          bq.push_back('{{24'h0, tmp[7:0]}, t0 + 41});
          bq.push_back('{{24'h0, tmp[7:0]}, t0 + 42});
        end else begin
          bq.push_back('{{24'h0, tmp[7:0]}, t0 + 42 + k});
        end
      end else begin
        bq.push_back('{{24'h0, tmp[7:0]}, t0 + 35 + k});
      end
    end
    len = 36 + OUT_BYTES + extra;
    if (hold > len) len = hold;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (i == hold) start_calc = 1'b0;
      if (mode == 1) begin
        if (cyc == t0 + 10) ena = 1'b0;
        if (cyc == t0 + 15) ena = 1'b1;
        if (cyc == t0 + 40) ena = 1'b0;
        if (cyc == t0 + 42) ena = 1'b1;
      end
      if (mode == 2 && i >= 3 && i <= 20) begin
        start_calc = i[0];
        a0 = $urandom;
        a1 = $urandom;
      end
      if (mode == 2 && i == 21) start_calc = 1'b0;
      if (cyc == t0) chk("busy_after_accept", 32'(core_busy), 32'h1);
      if (cyc == t0 + 34 + OUT_BYTES + extra) chk("busy_before_end", 32'(core_busy), 32'h1);
      if (cyc == t0 + 35 + OUT_BYTES + extra) chk("busy_after_end", 32'(core_busy), 32'h0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(core_busy),    32'h0);
    chk({tag, "_result"}, result,            32'h0);
    chk({tag, "_valid"},  32'(result_valid), 32'h0);
    chk({tag, "_byte"},   32'(out_byte),     32'h0);
    chk({tag, "_strobe"}, 32'(out_strobe),   32'h0);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int t0;
    rst = 1'b1; ena = 1'b1; start_calc = 1'b0; a0 = '0; a1 = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue(32'd3,          -32'sd5,       32'hFFFF_FFF1, 1, 0);
    issue(32'h4000_0000,  32'd4,         SAT ? 32'h7FFF_FFFF : 32'h0, 1, 0);
    issue(32'h8000_0000,  32'h8000_0000, SAT ? 32'h7FFF_FFFF : 32'h0, 1, 0);
    issue(32'd0,          32'd12345,     32'h0, 1, 0);
    issue(-32'sd7,        -32'sd9,       32'h0000_003F, 1, 0);
    issue(32'h7FFF_FFFF,  -32'sd1,       32'h8000_0001, 1, 0);
    issue(32'h8000_0000,  32'd1,         32'h8000_0000, 1, 0);
    issue(32'h8000_0000,  -32'sd1,       SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1, 0);
    issue(32'd1000,       -32'sd1000,    32'hFFF0_BDC0, 1, 0);
    issue(32'h0001_0000,  -32'sd65536,   SAT ? 32'h8000_0000 : 32'h0, 1, 0);

    // Abort ten cycles into MUL; nothing may be emitted.
    @(negedge clk);
    a0 = 32'd77; a1 = 32'd88; start_calc = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start_calc = 1'b0;
    while (cyc < t0 + 11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(32'd12, 32'd13, 32'h0000_009C, 1, 0);

    issue(32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 1, 1);
    issue(32'd100, 32'd200, 32'h0000_4E20, 60, 0);
    issue(-32'sd2, 32'd3, 32'hFFFF_FFFA, 1, 0);
    issue(32'h0102_0304, 32'd2, 32'h0204_0608, 1, 2);

    repeat (10) @(negedge clk);
    chk("results_drained", 32'(rq.size()), 32'h0);
    chk("bytes_drained",   32'(bq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
